// File: rtl/uart_display_scroller.sv
// uart_display_scroller
// Collects UART bytes as hex nibbles (high nibble first) and presents a
// 4-digit window to the 7-segment anode driver. Up to four digits are shown
// right-aligned. Beyond four digits the window scrolls through the message
// and wraps around at the current message length.
//
// Input handshake: rx_valid is a single-cycle strobe with no back-pressure.
// rx_data and rx_error are sampled only in a cycle where rx_valid=1. A byte
// that cannot be stored is dropped and noted in a sticky flag.
module uart_display_scroller #(
   parameter int DEPTH      = 16,
   parameter int SCROLL_DIV = 25000000,
   parameter int CW         = 25
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [7:0]               rx_data,
   input  logic                     rx_valid,
   input  logic                     rx_error,
   input  logic                     clear,
   output logic [15:0]              word,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     scrolling,
   output logic                     overflow,
   output logic                     rx_err_seen,
   output logic [1:0]               dbg_state
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = AW + 1;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_FILL   = 2'd1,
      ST_SCROLL = 2'd2
   } state_t;

   // Registers
   state_t            r_state;
   logic              r_scrolling;
   logic [3:0]        r_buf [DEPTH];
   logic [CNTW-1:0]   r_count;
   logic [CNTW-1:0]   r_ptr;
   logic [CW-1:0]     r_tick;
   logic [15:0]       r_word;
   logic              r_overflow;
   logic              r_err_seen;

   // Combinational signals
   state_t            w_state_nxt;
   logic              w_store;
   logic              w_drop_full;
   logic [CNTW-1:0]   w_count_nxt;
   logic [AW-1:0]     w_wr_idx;
   logic [AW-1:0]     w_wr_idx1;
   logic              w_tick_term;
   logic [CNTW-1:0]   w_ptr_inc;
   logic [CNTW:0]     w_spos   [4];
   logic [CNTW:0]     w_fpos   [4];
   logic [AW-1:0]     w_sidx   [4];
   logic [AW-1:0]     w_fidx   [4];
   logic [3:0]        w_digit  [4];
   logic [15:0]       w_word_nxt;

   assign w_wr_idx    = r_count[AW-1:0];
   assign w_wr_idx1   = w_wr_idx + AW'(1);
   assign w_tick_term = (r_tick == CW'(SCROLL_DIV - 1));
   assign w_ptr_inc   = r_ptr + CNTW'(1);

   // Byte acceptance: error bytes are never stored, full buffer drops the byte
   always_comb begin
      w_store     = 1'b0;
      w_drop_full = 1'b0;
      w_count_nxt = r_count;
      if (rx_valid && !rx_error) begin
         if (r_count <= CNTW'(DEPTH - 2)) begin
            w_store     = 1'b1;
            w_count_nxt = r_count + CNTW'(2);
         end else begin
            w_drop_full = 1'b1;
         end
      end
   end

   // FSM next state: advances on the count that is being written this cycle
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: begin
            if (w_count_nxt > CNTW'(4))
               w_state_nxt = ST_SCROLL;
            else if (w_count_nxt != '0)
               w_state_nxt = ST_FILL;
         end
         ST_FILL: begin
            if (w_count_nxt > CNTW'(4))
               w_state_nxt = ST_SCROLL;
         end
         ST_SCROLL: begin
            w_state_nxt = ST_SCROLL;
         end
         default: begin
            w_state_nxt = ST_EMPTY;
         end
      endcase
      if (clear)
         w_state_nxt = ST_EMPTY;
   end

   // FSM state register with scrolling flag registered alongside
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_EMPTY;
         r_scrolling <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_scrolling <= (w_state_nxt == ST_SCROLL);
      end
   end

   // Count and sticky status flags
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_err_seen <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         if (w_drop_full)
            r_overflow <= 1'b1;
         if (rx_valid && rx_error)
            r_err_seen <= 1'b1;
      end
   end

   // Nibble buffer write, high nibble at the lower address
   always_ff @(posedge clk) begin
      if (!reset && !clear && w_store) begin
         r_buf[w_wr_idx]  <= rx_data[7:4];
         r_buf[w_wr_idx1] <= rx_data[3:0];
      end
   end

   // Scroll pointer and tick; held at zero outside SCROLL so entry starts at 0
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_ptr  <= '0;
         r_tick <= '0;
      end else if (r_state != ST_SCROLL) begin
         r_ptr  <= '0;
         r_tick <= '0;
      end else if (w_tick_term) begin
         r_tick <= '0;
         // Wrap against the count being written now, so an append extends the lap
         r_ptr  <= (w_ptr_inc == w_count_nxt) ? '0 : w_ptr_inc;
      end else begin
         r_tick <= r_tick + CW'(1);
      end
   end

   // Window index math: scroll index wraps once (ptr < count, count > 4),
   // fill index right-aligns the stored nibbles against digit 3
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_spos[k] = {1'b0, r_ptr} + (CNTW+1)'(k);
         w_fpos[k] = {1'b0, r_count} + (CNTW+1)'(k);
         w_sidx[k] = (w_spos[k] >= {1'b0, r_count}) ?
                     AW'(w_spos[k] - {1'b0, r_count}) : AW'(w_spos[k]);
         w_fidx[k] = AW'(w_fpos[k] - (CNTW+1)'(4));
      end
   end

   // Digit select per state; digit 0 is the leftmost
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_digit[k] = 4'h0;
         case (r_state)
            ST_SCROLL: w_digit[k] = r_buf[w_sidx[k]];
            ST_FILL: begin
               if (w_fpos[k] >= (CNTW+1)'(4))
                  w_digit[k] = r_buf[w_fidx[k]];
            end
            default: w_digit[k] = 4'h0;
         endcase
      end
      w_word_nxt = {w_digit[0], w_digit[1], w_digit[2], w_digit[3]};
   end

   // Registered display word
   always_ff @(posedge clk) begin
      if (reset || clear)
         r_word <= 16'h0000;
      else
         r_word <= w_word_nxt;
   end

   assign word        = r_word;
   assign count       = r_count;
   assign scrolling   = r_scrolling;
   assign overflow    = r_overflow;
   assign rx_err_seen = r_err_seen;
   assign dbg_state   = r_state;

endmodule
